// File: rtl/updown_seq_monitor_pkg.sv
// Shared definitions for the up/down sequence monitor: state encodings,
// counter sizing and the endpoint derivation.
package updown_seq_monitor_pkg;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    ACQ    = ST_ACQ,
    LOCKED = ST_LOCKED
  } mon_state_e;

  // good-step counter is wide enough for lock thresholds up to 15
  localparam int unsigned GOOD_W = 4;

  function automatic int unsigned max_of(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/updown_predict.sv
// Combinational next-value / next-direction predictor for the bouncing
// 0..MAX..0 counter sequence.
module updown_predict
  import updown_seq_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] prev,
  input  logic             dir,
  output logic [WIDTH-1:0] pred_c,
  output logic             dir_next_c
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));

  // endpoints reverse direction instead of wrapping
  always_comb begin
    pred_c     = prev;
    dir_next_c = dir;
    if (dir) begin
      if (prev == MAX) begin
        pred_c     = prev - WIDTH'(1);
        dir_next_c = 1'b0;
      end else begin
        pred_c = prev + WIDTH'(1);
      end
    end else begin
      if (prev == '0) begin
        pred_c     = WIDTH'(1);
        dir_next_c = 1'b1;
      end else begin
        pred_c = prev - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/updown_seq_monitor.sv
// Receive-side checker for the bouncing up/down counter: locks onto the
// sequence and reports direction, turnarounds, periods and errors.
module updown_seq_monitor
  import updown_seq_monitor_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  output logic             dir,
  output logic             locked,
  output logic             turn,
  output logic             period_done,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [WIDTH-1:0]  MAX      = WIDTH'(max_of(WIDTH));
  localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);

  mon_state_e        state, state_nxt;
  logic              dir_nxt, locked_nxt, turn_nxt, period_done_nxt, err_nxt;
  logic [ERR_W-1:0]  err_count_nxt;
  logic [GOOD_W-1:0] good_cnt, good_cnt_nxt;
  logic [WIDTH-1:0]  prev, prev_nxt;
  logic              en_d;

  logic [WIDTH-1:0]  pred_c;
  logic              dir_next_c;
  logic              step_up_c, step_dn_c, mismatch_c;
  logic [ERR_W-1:0]  err_inc_c;

  updown_predict #(.WIDTH(WIDTH)) u_predict (
    .prev       (prev),
    .dir        (dir),
    .pred_c     (pred_c),
    .dir_next_c (dir_next_c)
  );

  // +/-1 steps during acquisition; the MAX->0 wrap never counts as +1
  assign step_up_c = (prev != MAX) && (count_in == prev + WIDTH'(1));
  assign step_dn_c = (prev != '0)  && (count_in == prev - WIDTH'(1));

  // sampled value off-sequence, or count moved while no step was due
  assign mismatch_c = en_d ? (count_in != pred_c) : (count_in != prev);
  assign err_inc_c  = (err_count == '1) ? err_count : err_count + ERR_W'(1);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= HUNT;
      dir         <= 1'b1;
      locked      <= 1'b0;
      turn        <= 1'b0;
      period_done <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
      good_cnt    <= '0;
      prev        <= '0;
      en_d        <= 1'b0;
    end else begin
      state       <= state_nxt;
      dir         <= dir_nxt;
      locked      <= locked_nxt;
      turn        <= turn_nxt;
      period_done <= period_done_nxt;
      err         <= err_nxt;
      err_count   <= err_count_nxt;
      good_cnt    <= good_cnt_nxt;
      prev        <= prev_nxt;
      en_d        <= enable;
    end
  end

  always_comb begin
    state_nxt       = state;
    dir_nxt         = dir;
    locked_nxt      = locked;
    turn_nxt        = 1'b0;
    period_done_nxt = 1'b0;
    err_nxt         = 1'b0;
    err_count_nxt   = err_count;
    good_cnt_nxt    = good_cnt;
    prev_nxt        = prev;

    case (state)
      HUNT: begin
        if (en_d) begin
          prev_nxt  = count_in;
          state_nxt = ACQ;
        end
      end

      ACQ: begin
        if (en_d) begin
          prev_nxt = count_in;
          if (step_up_c || step_dn_c) begin
            dir_nxt = step_up_c;
            if (good_cnt + GOOD_W'(1) == LOCK_TGT) begin
              state_nxt    = LOCKED;
              locked_nxt   = 1'b1;
              good_cnt_nxt = '0;
            end else begin
              good_cnt_nxt = good_cnt + GOOD_W'(1);
            end
          end else begin
            good_cnt_nxt = '0;
          end
        end
      end

      LOCKED: begin
        if (mismatch_c) begin
          err_nxt       = 1'b1;
          err_count_nxt = err_inc_c;
          locked_nxt    = 1'b0;
          good_cnt_nxt  = '0;
          prev_nxt      = count_in;
          state_nxt     = ACQ;
        end else if (en_d) begin
          prev_nxt        = count_in;
          dir_nxt         = dir_next_c;
          turn_nxt        = (dir_next_c != dir);
          period_done_nxt = (count_in == '0) && !dir;
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

endmodule

// File: tb/tb_updown_seq_monitor.sv
// Scoreboard bench for updown_seq_monitor: a phase-based reference model
// queues expected outputs each edge; a monitor pops and compares them.
module tb_updown_seq_monitor;

  localparam int WIDTH    = 3;
  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 8;
  localparam int MAXV     = (1 << WIDTH) - 1;
  localparam int ERRMAX   = (1 << ERR_W) - 1;
  localparam int PER      = 2 * MAXV;
  localparam int OW       = 5 + ERR_W;

  localparam int M_HUNT = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic             clock;
  logic             clear;
  logic             enable;
  logic [WIDTH-1:0] count_in;
  logic             dir, locked, turn, period_done, err;
  logic [ERR_W-1:0] err_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [OW-1:0] expq[$];

  int m_mode, m_prev, m_good, m_errc;
  bit m_dir, m_en_d;

  updown_seq_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clock       (clock),
    .clear       (clear),
    .enable      (enable),
    .count_in    (count_in),
    .dir         (dir),
    .locked      (locked),
    .turn        (turn),
    .period_done (period_done),
    .err         (err),
    .err_count   (err_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // value of the bouncing sequence at phase ph (0..PER-1)
  function automatic int seq_val(input int ph);
    return (ph <= MAXV) ? ph : PER - ph;
  endfunction

  task automatic model_step();
    bit t, p, e;
    t = 1'b0; p = 1'b0; e = 1'b0;
    if (clear) begin
      m_mode = M_HUNT; m_dir = 1'b1; m_prev = 0; m_good = 0;
      m_errc = 0; m_en_d = 1'b0;
    end else begin
      int cnt;
      cnt = int'(count_in);
      if (m_mode == M_HUNT) begin
        if (m_en_d) begin
          m_prev = cnt;
          m_mode = M_ACQ;
        end
      end else if (m_mode == M_ACQ) begin
        if (m_en_d) begin
          if (cnt - m_prev == 1 || m_prev - cnt == 1) begin
            m_dir  = (cnt > m_prev);
            m_good = m_good + 1;
            if (m_good == LOCK_CNT) begin
              m_mode = M_LOCK;
              m_good = 0;
            end
          end else begin
            m_good = 0;
          end
          m_prev = cnt;
        end
      end else begin
        int ph, nph, want;
        bit nd, bad_step;
        ph   = m_dir ? m_prev : (PER - m_prev) % PER;
        nph  = (ph + 1) % PER;
        want = seq_val(nph);
        nd   = (nph >= 1) && (nph <= MAXV);
        bad_step = m_en_d ? (cnt != want) : (cnt != m_prev);
        if (bad_step) begin
          e = 1'b1;
          if (m_errc < ERRMAX) m_errc = m_errc + 1;
          m_mode = M_ACQ;
          m_good = 0;
          m_prev = cnt;
        end else if (m_en_d) begin
          t = (nd != m_dir);
          p = (cnt == 0) && !m_dir;
          m_prev = cnt;
          m_dir  = nd;
        end
      end
      m_en_d = enable;
    end
    expq.push_back({m_dir, (m_mode == M_LOCK), t, p, e, ERR_W'(m_errc)});
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  // monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    forever begin
      logic [OW-1:0] want, got;
      @(negedge clock);
      cyc = cyc + 1;
      if (expq.size() > 0) begin
        want = expq.pop_front();
        got  = {dir, locked, turn, period_done, err, err_count};
        total = total + 1;
        if (got !== want) begin
          bad = bad + 1;
          $display("FAIL outputs cyc=%0d got dir=%b locked=%b turn=%b pd=%b err=%b errc=%0d want dir=%b locked=%b turn=%b pd=%b err=%b errc=%0d",
                   cyc, got[OW-1], got[OW-2], got[OW-3], got[OW-4], got[OW-5], got[ERR_W-1:0],
                   want[OW-1], want[OW-2], want[OW-3], want[OW-4], want[OW-5], want[ERR_W-1:0]);
        end
      end
    end
  end

  task automatic drive(input bit clr, input bit en, input int cnt);
    @(negedge clock);
    #1;
    clear    = clr;
    enable   = en;
    count_in = WIDTH'(cnt);
  endtask

  task automatic run_seq(input int vals[$]);
    foreach (vals[i]) drive(1'b0, 1'b1, vals[i]);
  endtask

  task automatic check_reset_now(input string name);
    logic [OW-1:0] got, want;
    got  = {dir, locked, turn, period_done, err, err_count};
    want = {1'b1, 4'b0000, ERR_W'(0)};
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  initial begin
    int q[$];
    int ph;
    bit en_prev;
    clear = 1'b1; enable = 1'b0; count_in = '0;
    repeat (3) drive(1'b1, 1'b0, 0);

    // lock on 0,1,2; run up, turn at 7, period at 0, turn at 0->1, jump error, relock
    q = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 5, 6, 7, 6, 5};
    run_seq(q);
    // last sample of 4, then a spurious change to 6 with no step due
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 6);
    drive(1'b0, 1'b0, 6);

    // wrap 7 -> 0 while locked up is an error
    drive(1'b1, 1'b0, 0);
    q = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
    run_seq(q);
    drive(1'b0, 1'b1, 4);
    // asynchronous clear while locked
    #1 clear = 1'b1;
    #1 check_reset_now("async_clear");
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 0);

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      q = '{3, 4, 5, 0};
      run_seq(q);
    end
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    total = total + 1;
    if (err_count !== ERR_W'(ERRMAX)) begin
      bad = bad + 1;
      $display("FAIL err_sat got=%0d want=%0d", err_count, ERRMAX);
    end

    // randomized counter trace with glitches, enable gaps and occasional clear
    ph = $urandom_range(0, PER - 1);
    en_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int v;
      bit en, clr;
      if (en_prev) ph = (ph + 1) % PER;
      v = seq_val(ph);
      if ($urandom_range(0, 99) < 3) v = int'($urandom_range(0, MAXV));
      en  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 999) < 3);
      drive(clr, en, v);
      en_prev = en;
    end
    drive(1'b0, 1'b0, seq_val(ph));
    drive(1'b0, 1'b0, seq_val(ph));
    @(negedge clock);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
